// File: rtl/cdclib_pulse_shrink_pkg.sv
// Shared types and constants for the cdclib pulse shrinker.
package cdclib_pulse_shrink_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } state_e;

    localparam int             CNT_W    = 2;
    localparam int             PCNT_W   = 8;
    localparam logic [PCNT_W-1:0] PCNT_MAX = 8'hFF;

endpackage

// File: rtl/cdclib_pulse_shrink_sync.sv
// Two-flop synchronizer with synchronous active-high reset to RESET_VAL.
module cdclib_pulse_shrink_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/cdclib_pulse_shrink.sv
// Qualifies a stretched pulse level and emits one single-cycle pulse per event.
// Optional input synchronizer enabled by CDCLIB_PULSE_SHRINK_SYNC_EN.
module cdclib_pulse_shrink
    import cdclib_pulse_shrink_pkg::*;
#(
    parameter int RESET_VAL  = 0,
    parameter int HIGH_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        r_num_stages,
    input  logic              cnt_clr,
    input  logic              data_in,
    output logic              pulse_out,
    output logic              data_out,
    output logic              pulse_err,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam logic ACT_LVL = (HIGH_PULSE != 0);
    localparam logic RST_LVL = (RESET_VAL != 0);

    logic              din_s;
    logic              in_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pulse_q, pulse_d;
    logic              err_q, err_d;
    logic              dout_q, dout_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

`ifdef CDCLIB_PULSE_SHRINK_SYNC_EN
    cdclib_pulse_shrink_sync #(
        .RESET_VAL (~ACT_LVL)
    ) u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (data_in),
        .q_o   (din_s)
    );
`else
    assign din_s = data_in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_q) begin
                    if (r_num_stages == 2'd0) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = QUAL;
                        cnt_d   = 2'd1;
                    end
                end
            end
            QUAL: begin
                if (!in_q) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q >= r_num_stages) begin
                    state_d = ACTIVE;
                    pulse_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ACTIVE: begin
                if (!in_q) begin
                    if (r_num_stages == 2'd0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = 2'd1;
                    end
                end
            end
            GAP: begin
                // A short dropout returns to ACTIVE without re-firing pulse_out.
                if (in_q) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q >= r_num_stages) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dout_d = ((state_d == ACTIVE) || (state_d == GAP)) ? ACT_LVL : ~ACT_LVL;
        // Counter moves on the same edge as pulse_out; a clear on that edge wins.
        if (cnt_clr) begin
            pcnt_d = '0;
        end else if (pulse_d && (pcnt_q != PCNT_MAX)) begin
            pcnt_d = pcnt_q + 8'd1;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= RST_LVL;
            pcnt_q  <= '0;
        end else begin
            in_q    <= ACT_LVL ? din_s : ~din_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign pulse_out = pulse_q;
    assign pulse_err = err_q;
    assign data_out  = dout_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_cdclib_pulse_shrink.sv
// Bench for cdclib_pulse_shrink: run-length reference model plus directed event scenarios.
module tb_cdclib_pulse_shrink;

`ifdef CDCLIB_PULSE_SHRINK_SYNC_EN
    localparam int LAT_ADD = 2;
`else
    localparam int LAT_ADD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] r_num_stages = 2'd0;
    logic       cnt_clr = 1'b0;
    logic       din = 1'b0;

    logic       pulse_out_a, data_out_a, pulse_err_a;
    logic [7:0] pulse_cnt_a;
    logic       pulse_out_b, data_out_b, pulse_err_b;
    logic [7:0] pulse_cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: active-high input, idles low.
    cdclib_pulse_shrink #(.RESET_VAL(0), .HIGH_PULSE(1)) dut_a (
        .clk(clk), .rst(rst), .r_num_stages(r_num_stages), .cnt_clr(cnt_clr),
        .data_in(din), .pulse_out(pulse_out_a), .data_out(data_out_a),
        .pulse_err(pulse_err_a), .pulse_cnt(pulse_cnt_a));

    // Instance B: active-low input fed the inverse of din, so it sees the same events.
    cdclib_pulse_shrink #(.RESET_VAL(1), .HIGH_PULSE(0)) dut_b (
        .clk(clk), .rst(rst), .r_num_stages(r_num_stages), .cnt_clr(cnt_clr),
        .data_in(~din), .pulse_out(pulse_out_b), .data_out(data_out_b),
        .pulse_err(pulse_err_b), .pulse_cnt(pulse_cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: counts consecutive active samples to qualify an event and
    // consecutive inactive samples to end it, using the live qualification width.
    logic m_inq [2], m_s1 [2], m_s2 [2], m_evt [2], m_pulse [2], m_err [2], m_dout [2];
    int   m_run [2], m_cnt [2];
    bit   mdl_ok = 1'b0;

    always @(posedge clk) begin : model
        int   n;
        logic raw, act, smp;
        n = int'(r_num_stages);
        for (int i = 0; i < 2; i++) begin
            act = (i == 0);
            raw = (i == 0) ? din : ~din;
            if (rst) begin
                m_inq[i] = 1'b0; m_s1[i] = ~act; m_s2[i] = ~act;
                m_evt[i] = 1'b0; m_run[i] = 0; m_pulse[i] = 1'b0; m_err[i] = 1'b0;
                m_dout[i] = (i == 1); m_cnt[i] = 0;
            end else begin
                smp = m_inq[i];
`ifdef CDCLIB_PULSE_SHRINK_SYNC_EN
                m_inq[i] = (m_s2[i] == act);
                m_s2[i]  = m_s1[i];
                m_s1[i]  = raw;
`else
                m_inq[i] = (raw == act);
`endif
                m_pulse[i] = 1'b0;
                m_err[i]   = 1'b0;
                if (!m_evt[i]) begin
                    if (smp) begin
                        m_run[i]++;
                        if (m_run[i] >= n + 1) begin
                            m_evt[i] = 1'b1; m_pulse[i] = 1'b1; m_run[i] = 0;
                        end
                    end else begin
                        if (m_run[i] > 0) m_err[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    if (!smp) begin
                        m_run[i]++;
                        if (m_run[i] >= n + 1) begin
                            m_evt[i] = 1'b0; m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_dout[i] = m_evt[i] ? act : ~act;
                if (cnt_clr) m_cnt[i] = 0;
                else if (m_pulse[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
        end
        if (rst) mdl_ok = 1'b1;
    end

    always @(negedge clk) begin : compare
        if (mdl_ok) begin
            chk("cmp_pulse_a", pulse_out_a, m_pulse[0]);
            chk("cmp_err_a",   pulse_err_a, m_err[0]);
            chk("cmp_dout_a",  data_out_a,  m_dout[0]);
            chk("cmp_cnt_a",   pulse_cnt_a, m_cnt[0]);
            chk("cmp_pulse_b", pulse_out_b, m_pulse[1]);
            chk("cmp_err_b",   pulse_err_b, m_err[1]);
            chk("cmp_dout_b",  data_out_b,  m_dout[1]);
            chk("cmp_cnt_b",   pulse_cnt_b, m_cnt[1]);
        end
    end

    // Cumulative event monitors used by the directed literal checks.
    int npa = 0, nea = 0, dha = 0, pa_cyc = 0, lasthi_a = 0;
    int npb = 0, dhb = 0, pb_cyc = 0;

    always @(negedge clk) begin : monitor
        if (pulse_out_a === 1'b1) begin npa++; pa_cyc = cyc; end
        if (pulse_err_a === 1'b1) nea++;
        if (data_out_a === 1'b1) begin dha++; lasthi_a = cyc; end
        if (pulse_out_b === 1'b1) begin npb++; pb_cyc = cyc; end
        if (data_out_b === 1'b0) dhb++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0, b_np, b_ne, b_dh, b_npb, b_dhb;

    task automatic snap();
        b_np = npa; b_ne = nea; b_dh = dha; b_npb = npb; b_dhb = dhb;
    endtask

    initial begin
        // Reset state
        rst = 1'b1; din = 1'b0; step(2);
        chk("rst_pulse_a", pulse_out_a, 0);
        chk("rst_err_a",   pulse_err_a, 0);
        chk("rst_cnt_a",   pulse_cnt_a, 0);
        chk("rst_dout_a",  data_out_a,  0);
        chk("rst_dout_b",  data_out_b,  1);
        rst = 1'b0; step(2);

        // N=0, high for 4 cycles
        r_num_stages = 2'd0; snap(); t0 = cyc;
        din = 1'b1; step(4); din = 1'b0; step(6);
        chk("t1_pulses",  npa - b_np, 1);
        chk("t1_latency", pa_cyc - t0, 2 + LAT_ADD);
        chk("t1_dout_hi", dha - b_dh, 4);
        chk("t1_cnt",     pulse_cnt_a, 1);

        // N=2 runt pulse
        rst = 1'b1; step(1); rst = 1'b0;
        r_num_stages = 2'd2; step(1); snap();
        din = 1'b1; step(2); din = 1'b0; step(8);
        chk("t2_pulses",  npa - b_np, 0);
        chk("t2_err",     nea - b_ne, 1);
        chk("t2_dout_hi", dha - b_dh, 0);
        chk("t2_cnt",     pulse_cnt_a, 0);

        // N=2 dropout absorbed in GAP
        snap(); t0 = cyc;
        din = 1'b1; step(6); din = 1'b0; step(1); din = 1'b1; step(5);
        t0 = cyc; din = 1'b0; step(8);
        chk("t3_pulses",  npa - b_np, 1);
        chk("t3_dout_hi", dha - b_dh, 12);
        chk("t3_fall",    lasthi_a - t0, 3 + LAT_ADD);

        // Active-low instance, N=1, low for 3 cycles
        r_num_stages = 2'd1; snap(); t0 = cyc;
        din = 1'b1; step(3); din = 1'b0; step(6);
        chk("t4_pulses_b",  npb - b_npb, 1);
        chk("t4_latency_b", pb_cyc - t0, 3 + LAT_ADD);
        chk("t4_dout_lo_b", dhb - b_dhb, 3);
        chk("t4_idle_b",    data_out_b, 1);

        // Width reduced mid-qualification completes next cycle
        r_num_stages = 2'd3; snap(); t0 = cyc;
        din = 1'b1; step(2 + LAT_ADD); r_num_stages = 2'd0; step(1); din = 1'b0; step(4);
        chk("live_pulses",  npa - b_np, 1);
        chk("live_latency", pa_cyc - t0, 3 + LAT_ADD);

        // Stuck active: one pulse, stays active
        r_num_stages = 2'd1; snap();
        din = 1'b1; step(30);
        chk("stuck_pulses", npa - b_np, 1);
        chk("stuck_dout",   data_out_a, 1);
        din = 1'b0; step(6);
        chk("stuck_release", data_out_a, 0);

        // Saturation with N=0, minimum one-sample gaps
        rst = 1'b1; step(1); rst = 1'b0; r_num_stages = 2'd0; step(1); snap();
        for (int i = 0; i < 260; i++) begin
            din = 1'b1; step(1); din = 1'b0; step(1);
        end
        step(4);
        chk("sat_pulses", npa - b_np, 260);
        chk("sat_cnt_a",  pulse_cnt_a, 255);
        chk("sat_cnt_b",  pulse_cnt_b, 255);

        // Clear on the same edge that raises pulse_out
        din = 1'b1; step(1 + LAT_ADD); cnt_clr = 1'b1; step(1);
        chk("clr_pulse", pulse_out_a, 1);
        chk("clr_cnt",   pulse_cnt_a, 0);
        cnt_clr = 1'b0; din = 1'b0; step(4);
        din = 1'b1; step(1); din = 1'b0; step(4 + LAT_ADD);
        chk("clr_recount", pulse_cnt_a, 1);

        // Reset while qualifying, input held high afterwards
        r_num_stages = 2'd2; snap();
        din = 1'b1; step(2 + LAT_ADD);
        rst = 1'b1; step(1);
        chk("q_rst_pulse", pulse_out_a, 0);
        chk("q_rst_err",   pulse_err_a, 0);
        chk("q_rst_cnt",   pulse_cnt_a, 0);
        chk("q_rst_dout_a", data_out_a, 0);
        chk("q_rst_dout_b", data_out_b, 1);
        rst = 1'b0; t0 = cyc; step(10);
        chk("q_rst_pulses",  npa - b_np, 1);
        chk("q_rst_latency", pa_cyc - t0, 4 + LAT_ADD);
        din = 1'b0; step(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
